// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, line address and the memory-stall controller state.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [11:0] lc3b_wb_adr;

  typedef enum logic [1:0] {
    S_IDLE,
    S_IND,
    S_FINAL
  } mem_stall_state_t;

  localparam int STALL_CNT_W = 32;

  // Clamp a requested indirection depth to what the controller was built for.
  function automatic int unsigned sat_level(input int unsigned level,
                                            input int unsigned max_level);
    return (level > max_level) ? max_level : level;
  endfunction

endpackage

// File: rtl/stall_cycle_counter.sv
// Saturating count of pipeline-stall cycles; only built when STALL_PERF_CNT_EN is defined.
module stall_cycle_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage stall controller: walks LDI/STI pointer chains and freezes the pipeline meanwhile.
// Optional stall-cycle counter port when STALL_PERF_CNT_EN is defined.
module mem_stall_ctrl
  import lc3b_types::*;
#(
  parameter  int ADDR_W   = 16,
  parameter  int OFFSET_W = 4,
  parameter  int MAX_IND  = 1,
  localparam int LINE_W   = ADDR_W - OFFSET_W,
  localparam int LVL_W    = $clog2(MAX_IND + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read_in,
  input  logic                mem_write_in,
  input  logic [LINE_W-1:0]   mem_address_in,
  input  logic [OFFSET_W-1:0] line_offset_in,
  input  logic [LVL_W-1:0]    ind_level,
  input  logic                ind_write,
  input  logic                flushed,
  input  logic                mem_resp,
  input  logic                ifetch_resp,
  input  logic [ADDR_W-1:0]   mem_rdata,
  output logic                stall_pipeline,
  output logic                mem_read,
  output logic                mem_write,
  output logic [LINE_W-1:0]   mem_address,
  output logic [OFFSET_W-1:0] line_offset_out,
  output logic                busy
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  mem_stall_state_t  state;
  logic [ADDR_W-1:0] ptr;
  logic [LVL_W-1:0]  lvl;
  logic              flush_seen;
  logic [LVL_W-1:0]  eff_level;
  logic              ind_start;
  logic              flush_now;

  assign eff_level = LVL_W'(sat_level(32'(ind_level), MAX_IND));
  assign ind_start = (state == S_IDLE) && (eff_level != '0) && !flushed;
  // A flush pulse may arrive mid-access and be gone by the time mem_resp shows up.
  assign flush_now = flushed | flush_seen;

  always_comb begin
    mem_read        = mem_read_in;
    mem_write       = mem_write_in & ~mem_read_in;
    mem_address     = mem_address_in;
    line_offset_out = line_offset_in;
    stall_pipeline  = ((mem_read_in | mem_write_in) & ~mem_resp) | ~ifetch_resp;
    busy            = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (ind_start) begin
          mem_read       = 1'b1;
          mem_write      = 1'b0;
          stall_pipeline = 1'b1;
        end
      end
      S_IND: begin
        mem_read        = 1'b1;
        mem_write       = 1'b0;
        mem_address     = ptr[ADDR_W-1:OFFSET_W];
        line_offset_out = ptr[OFFSET_W-1:0];
        stall_pipeline  = 1'b1;
      end
      S_FINAL: begin
        mem_read        = ~ind_write;
        mem_write       = ind_write;
        mem_address     = ptr[ADDR_W-1:OFFSET_W];
        line_offset_out = ptr[OFFSET_W-1:0];
        stall_pipeline  = ~mem_resp;
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

  // lvl counts the pointer reads still outstanding after the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      lvl        <= '0;
      flush_seen <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          flush_seen <= 1'b0;
          if (ind_start && mem_resp) begin
            ptr   <= mem_rdata;
            lvl   <= eff_level - LVL_W'(1);
            state <= (eff_level > LVL_W'(1)) ? S_IND : S_FINAL;
          end
        end
        S_IND: begin
          if (flushed)
            flush_seen <= 1'b1;
          if (mem_resp) begin
            ptr <= mem_rdata;
            lvl <= lvl - LVL_W'(1);
            if (flush_now)
              state <= S_IDLE;
            else if (lvl == LVL_W'(1))
              state <= S_FINAL;
          end
        end
        S_FINAL: begin
          if (flushed)
            flush_seen <= 1'b1;
          if (mem_resp)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  stall_cycle_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_pipeline),
    .count(stall_cycles)
  );
`endif

endmodule

// File: doc/mem_stall_ctrl.md
MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 16, byte-address width of pointer/rdata word.
REQ-002 Parameter: OFFSET_W, default 4, line-offset width; line address width is ADDR_W-OFFSET_W.
REQ-003 Parameter: MAX_IND, default 1, maximum indirection levels (LDI/STI = 1); range 1..7.
REQ-004 Port: clk  in  1  sole clock, all state on rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: mem_read_in / mem_write_in  in  1 each  direct access request from MEM stage.
REQ-007 Port: mem_address_in  in  ADDR_W-OFFSET_W  line address from MEM stage.
REQ-008 Port: line_offset_in  in  OFFSET_W  offset from MEM stage.
REQ-009 Port: ind_level  in  clog2(MAX_IND+1)  indirection levels of current instr; 0 = direct.
REQ-010 Port: ind_write  in  1  final indirect access is a write (STI-class).
REQ-011 Port: flushed  in  1  MEM-stage instruction is squashed.
REQ-012 Port: mem_resp / ifetch_resp  in  1 each  data-side and fetch-side completion.
REQ-013 Port: mem_rdata  in  ADDR_W  data-side read data.
REQ-014 Port: stall_pipeline  out  1  freeze all pipeline registers.
REQ-015 Port: mem_read / mem_write  out  1 each; mem_address  out  ADDR_W-OFFSET_W; line_offset_out  out  OFFSET_W  data-side request.
REQ-016 Port: busy  out  1  high in any non-IDLE state.

Function
REQ-017 States SHALL be S_IDLE, S_IND, S_FINAL; outputs combinational from state and inputs.
REQ-018 S_IDLE, ind_level==0 or flushed: outputs pass through inputs; stall = ((read_in|write_in)&!mem_resp) | !ifetch_resp.
REQ-019 S_IDLE, ind_level>0 and !flushed: mem_read=1, mem_write=0 forced at input address/offset; stall=1.
REQ-020 In that case on mem_resp: ptr<=mem_rdata, lvl<=ind_level-1; go S_IND if ind_level>1 else S_FINAL.
REQ-021 ptr SHALL load only on the mem_resp cycle of a pointer read; never otherwise.
REQ-022 S_IND: mem_read=1, mem_write=0, mem_address=ptr[ADDR_W-1:OFFSET_W], line_offset_out=ptr[OFFSET_W-1:0], stall=1.
REQ-023 S_IND on mem_resp: ptr<=mem_rdata, lvl<=lvl-1; go S_FINAL when lvl==1, else stay.
REQ-024 S_FINAL: address/offset from ptr; mem_write=ind_write, mem_read=!ind_write; stall=!mem_resp.
REQ-025 S_FINAL on mem_resp: go S_IDLE; stall drops in that same cycle (1 pointer + 1 final access per level-1 instr, no dead cycle).
REQ-026 flushed rising while busy: current bus access SHALL hold until mem_resp, then go S_IDLE, skipping remaining phases; no final write issued.
REQ-027 mem_read and mem_write SHALL never both be 1 in any state.
REQ-028 ind_level > MAX_IND SHALL be saturated to MAX_IND.
REQ-029 mem_resp while request deasserted SHALL be ignored.

Reset
REQ-030 rst: state<=S_IDLE, ptr<=0, lvl<=0, counter<=0 next edge; outputs revert to IDLE pass-through.
REQ-031 rst mid-operation abandons the access; no ptr update even if mem_resp coincides.

Configuration
REQ-032 Macro STALL_PERF_CNT_EN defined: 32-bit output stall_cycles counts cycles with stall_pipeline=1, saturating at all-ones, cleared by rst.
REQ-033 Macro undefined: stall_cycles port and counter absent; all other behaviour identical.

Structure
REQ-034 lc3b_types SHALL hold lc3b_word, lc3b_wb_adr and new enum mem_stall_state_t {S_IDLE,S_IND,S_FINAL}.
REQ-035 Sub-module stall_cycle_counter SHALL implement REQ-032, instantiated only under STALL_PERF_CNT_EN.

Verification
REQ-036 Direct LDR, mem_resp after 3 cycles -> stall 1 for 3 cycles, 0 on resp cycle; busy stays 0.
REQ-037 LDI at line 0x010 offset 0x4, rdata 0x3A56 -> second read at line 0x3A5 offset 0x6; stall released on its resp.
REQ-038 STI ind_write=1, pointer 0x1200 -> write at line 0x120 offset 0x0; mem_read=0 throughout write phase.
REQ-039 MAX_IND=3, ind_level=3, pointers 0x1000->0x2002->0x3004 -> reads at 0x100, 0x200, final at line 0x300 offset 0x4; stall 0 only on final resp.
REQ-040 STI with flushed=1 during pointer read -> no write issued, busy 0 cycle after resp; rst in S_IND -> S_IDLE next edge, ptr=0.
REQ-041 With STALL_PERF_CNT_EN: 10 stalled cycles -> stall_cycles==10; rst -> 0.
